matrix_scroll_scan: RTL and testbench

// - Sits directly downstream of the 32x160 glyph-row ROM (5-bit row address in, 160-bit row out, MSB-first index 0..159).
// - Scans a 32-row LED dot-matrix one row at a time.
// - Cuts a 32-column window from each ROM row at a moving horizontal offset, giving a marquee scroll of the 5-glyph banner.

---
 rtl/matrix_scroll_scan_pkg.sv | 24 ++
 rtl/matrix_scroll_scan_window_select.sv | 23 ++
 rtl/matrix_scroll_scan.sv | 143 ++++++++++++++
 tb/tb_matrix_scroll_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scroll_scan_pkg.sv
// Shared constants, FSM encoding and scroll-step helper for the matrix_scroll_scan block.
package matrix_scroll_scan_pkg;

  localparam int ROWS  = 32;
  localparam int ROM_W = 160;
  localparam int WIN_W = 32;
  localparam int OFF_W = 8;
  localparam int ROW_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SHOW  = 3'd3,
    ST_BLANK = 3'd4
  } state_e;

  // One scroll step around the circular banner; right moves the window toward lower bit indices.
  function automatic logic [OFF_W-1:0] step_offset(input logic [OFF_W-1:0] off, input logic right);
    if (right) return (off == '0) ? OFF_W'(ROM_W - 1) : off - OFF_W'(1);
    return (off == OFF_W'(ROM_W - 1)) ? '0 : off + OFF_W'(1);
  endfunction

endpackage

// File: rtl/matrix_scroll_scan_window_select.sv
// Cuts a WIN_W-bit window out of a ROM row starting at offset, wrapping past bit ROM_W-1 back to bit 0.
module matrix_scroll_scan_window_select
  import matrix_scroll_scan_pkg::*;
(
  input  logic [0:ROM_W-1]  rom_data,
  input  logic [OFF_W-1:0]  offset,
  output logic [0:WIN_W-1]  window
);

  logic [OFF_W-1:0] idx;

  // NOTE: combinational blocks use blocking assignments so idx is reused safely within one pass.
  always_comb begin
    window = '0;
    idx    = '0;
    for (int j = 0; j < WIN_W; j++) begin
      idx = offset + OFF_W'(j);
      if (idx >= OFF_W'(ROM_W)) idx = idx - OFF_W'(ROM_W);
      window[j] = rom_data[idx];
    end
  end

endmodule

// File: rtl/matrix_scroll_scan.sv
// Row-scanned LED matrix driver with marquee scroll over a 32x160 glyph ROM.
// Define SCROLL_BIDIR_EN to let dir choose the scroll direction; otherwise scroll is always left.
module matrix_scroll_scan
  import matrix_scroll_scan_pkg::*;
#(
  parameter int ROW_DWELL       = 1000,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dir,
  output logic [ROW_W-1:0]  rom_addr,
  input  logic [0:ROM_W-1]  rom_data,
  output logic [ROWS-1:0]   row_sel,
  output logic [0:WIN_W-1]  col_data,
  output logic              frame_tick,
  output logic [OFF_W-1:0]  offset
);

  localparam int DW_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int FR_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(ROW_DWELL - 1);
  localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(FRAMES_PER_STEP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [FR_W-1:0]   frame_q, frame_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [ROW_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ROWS-1:0]   row_sel_q, row_sel_d;
  logic [0:WIN_W-1]  col_data_q, col_data_d;
  logic              frame_tick_q, frame_tick_d;
  logic [0:WIN_W-1]  window;
  logic              step_right;

`ifdef SCROLL_BIDIR_EN
  assign step_right = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign step_right = 1'b0;
`endif

  matrix_scroll_scan_window_select u_window_select (
    .rom_data (rom_data),
    .offset   (offset_q),
    .window   (window)
  );

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    dwell_d      = dwell_q;
    frame_d      = frame_q;
    offset_d     = offset_q;
    rom_addr_d   = rom_addr_q;
    col_data_d   = col_data_q;
    row_sel_d    = '0;
    frame_tick_d = 1'b0;

    if (!en) begin
      state_d    = ST_IDLE;
      row_d      = '0;
      dwell_d    = '0;
      frame_d    = '0;
      col_data_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_FETCH;
          row_d      = '0;
          rom_addr_d = '0;
        end
        ST_FETCH: state_d = ST_LATCH;
        ST_LATCH: begin
          state_d    = ST_SHOW;
          col_data_d = window;
          row_sel_d  = ROWS'(1) << row_q;
          dwell_d    = '0;
        end
        ST_SHOW: begin
          if (dwell_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            if (row_q == ROW_LAST) begin
              frame_tick_d = 1'b1;
              if (frame_q == FRAME_LAST) begin
                frame_d  = '0;
                offset_d = step_offset(offset_q, step_right);
              end else begin
                frame_d = frame_q + FR_W'(1);
              end
            end
          end else begin
            dwell_d   = dwell_q + DW_W'(1);
            row_sel_d = row_sel_q;
          end
        end
        ST_BLANK: begin
          state_d    = ST_FETCH;
          row_d      = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          rom_addr_d = row_d;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: only control/output flops exist here, so every one of them gets an async reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      dwell_q      <= '0;
      frame_q      <= '0;
      offset_q     <= '0;
      rom_addr_q   <= '0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      frame_q      <= frame_d;
      offset_q     <= offset_d;
      rom_addr_q   <= rom_addr_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign frame_tick = frame_tick_q;
  assign offset     = offset_q;

endmodule

// File: tb/tb_matrix_scroll_scan.sv
// Self-checking bench for matrix_scroll_scan: start-up vector table, arithmetic scan model, scroll and enable corners.
`timescale 1ns/1ps
module tb_matrix_scroll_scan;

  localparam int DWELL  = 4;
  localparam int FPS    = 2;
  localparam int PERIOD = DWELL + 3;
  localparam int FRAME  = 32 * PERIOD;
`ifdef SCROLL_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         dir;
  logic [4:0]   rom_addr;
  logic [0:159] rom_data;
  logic [31:0]  row_sel;
  logic [0:31]  col_data;
  logic         frame_tick;
  logic [7:0]   offset;

  logic [0:159] rom_mem [32];
  assign rom_data = rom_mem[rom_addr];

  always #5 clk = ~clk;

  matrix_scroll_scan #(.ROW_DWELL(DWELL), .FRAMES_PER_STEP(FPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dir        (dir),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_tick (frame_tick),
    .offset     (offset)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] rs;
    logic        tick;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int t;        // cycles since en was sampled, 0 = first FETCH cycle
  int ticks;    // frame_ticks since scanning (re)started
  int exp_off;

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
      if (n_fail >= 50) finish_run();
    end
  endtask

  function automatic logic [0:31] win(input logic [0:159] r, input int off);
    logic [0:31] w;
    for (int j = 0; j < 32; j++) w[j] = r[(off + j) % 160];
    return w;
  endfunction

  function automatic int step_model(input int off, input logic right);
    return right ? (off + 159) % 160 : (off + 1) % 160;
  endfunction

  task automatic start_run();
    en    = 1'b1;
    t     = -1;
    ticks = 0;
  endtask

  task automatic step_cycle(input int dir_mode);
    int row, ph, prev;
    logic [31:0]  exp_rs;
    logic [0:159] r;
    @(posedge clk);
    @(negedge clk);
    t++;
    row = (t / PERIOD) % 32;
    ph  = t % PERIOD;
    if (ph == PERIOD - 1 && row == 31) begin
      ticks++;
      if (ticks % FPS == 0) begin
        prev    = exp_off;
        exp_off = step_model(exp_off, BIDIR && dir);
        if (prev == 159 && exp_off == 0) check("offset_wrap", offset, 0);
      end
    end
    exp_rs = (ph >= 2 && ph < 2 + DWELL) ? (32'h1 << row) : 32'h0;
    check("rom_addr", rom_addr, row);
    check("row_sel", row_sel, exp_rs);
    check("frame_tick", frame_tick, (ph == PERIOD - 1 && row == 31));
    check("offset", offset, exp_off);
    if (exp_rs != 0) check("col_data", col_data, win(rom_mem[row], exp_off));
    if (exp_off == 150 && row == 0 && ph == 2) begin
      r = rom_mem[0];
      check("window_150", col_data, {r[150:159], r[0:21]});
    end
    case (dir_mode)
      0:       dir = 1'b0;
      1:       dir = 1'b1;
      default: dir = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_cycles(input int n, input int dir_mode);
    repeat (n) step_cycle(dir_mode);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [16];
    int   held;
    vecs = '{
      '{5'd0, 32'h0, 1'b0}, '{5'd0, 32'h0, 1'b0}, '{5'd0, 32'h1, 1'b0}, '{5'd0, 32'h1, 1'b0},
      '{5'd0, 32'h1, 1'b0}, '{5'd0, 32'h1, 1'b0}, '{5'd0, 32'h0, 1'b0}, '{5'd1, 32'h0, 1'b0},
      '{5'd1, 32'h0, 1'b0}, '{5'd1, 32'h2, 1'b0}, '{5'd1, 32'h2, 1'b0}, '{5'd1, 32'h2, 1'b0},
      '{5'd1, 32'h2, 1'b0}, '{5'd1, 32'h0, 1'b0}, '{5'd2, 32'h0, 1'b0}, '{5'd2, 32'h0, 1'b0}
    };
    rst_n   = 1'b0;
    en      = 1'b0;
    dir     = 1'b0;
    exp_off = 0;
    t       = 0;
    ticks   = 0;
    for (int r = 0; r < 32; r++)
      rom_mem[r] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};

    #12;
    check("rst_rom_addr", rom_addr, 0);
    check("rst_row_sel", row_sel, 0);
    check("rst_col_data", col_data, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_offset", offset, 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_row_sel", row_sel, 0);

    // Start-up timeline, dir held high through the first scroll step.
    dir = 1'b1;
    start_run();
    for (int i = 0; i < 16; i++) begin
      step_cycle(1);
      check("vec_rom_addr", rom_addr, vecs[i].addr);
      check("vec_row_sel", row_sel, vecs[i].rs);
      check("vec_frame_tick", frame_tick, vecs[i].tick);
    end
    run_cycles(2 * FRAME - 16, 1);
    check("dir_step", offset, BIDIR ? 159 : 1);

    run_cycles(18 * FRAME, 2);
    run_cycles(301 * FRAME, 0);

    // Drop en in the middle of row 5 SHOW, with the frame counter at an odd count.
    run_cycles(5 * PERIOD + 4, 0);
    held = exp_off;
    en   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_row_sel", row_sel, 0);
    check("drop_col_data", col_data, 0);
    check("drop_offset", offset, held);
    check("drop_frame_tick", frame_tick, 0);
    repeat (3) @(negedge clk);
    check("idle_offset_held", offset, held);
    check("idle_row_sel_held", row_sel, 0);

    start_run();
    run_cycles(3, 0);
    check("reenable_row0", row_sel, 32'h1);
    run_cycles(2 * FRAME - 3, 0);
    check("restart_step", offset, step_model(held, 1'b0));

    // Asynchronous reset while row 0 of the next frame is lit.
    run_cycles(3, 0);
    check("pre_reset_lit", row_sel, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_row_sel", row_sel, 0);
    check("async_frame_tick", frame_tick, 0);
    check("async_offset", offset, 0);
    check("async_col_data", col_data, 0);

    finish_run();
  end

endmodule
